// File: rtl/mc_alu_sequencer_if.sv
// Control bus between the multicycle sequencer and the datapath/memory:
// instruction fields and flags in, mux selects, write enables and mem handshake out.
interface mc_alu_sequencer_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [5:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, mdr_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src,
               pc_en, illegal, mem_err, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, mdr_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src,
               pc_en, illegal, mem_err, state_dbg
    );
endinterface

// File: rtl/mc_alu_sequencer.sv
// Multicycle main-control FSM: 3-5 states per instruction plus one per memory wait cycle.
// Memory stalls hold the state with mem_req stable; optional timeout parks the FSM in HALT.
module mc_alu_sequencer #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_alu_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  R_EX   = 4'd3,
        R_WB    = 4'd4,  MEM_ADR = 4'd5, MEM_RD = 4'd6,  MEM_WB = 4'd7,
        MEM_WR  = 4'd8,  I_EX   = 4'd9,  I_WB   = 4'd10, BRANCH = 4'd11,
        JUMP    = 4'd12, HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_NOR = 6'b100111;
    localparam logic [5:0] ALU_NOP = 6'b000000;

    localparam logic [CNT_W-1:0] CNT_LIM = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             req_st;
    logic             timed_out;
    logic             op_known;

    assign req_st    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A ready in the threshold cycle takes priority over the abort.
    assign timed_out = (MEM_TIMEOUT > 0) && req_st && !bus.mem_ready && (cnt == CNT_LIM);
    assign bus.state_dbg = state;

    always_comb begin
        op_known = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: op_known = 1'b1;
            default:                           op_known = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = FETCH;
            FETCH:   if (bus.mem_ready) nxt = DECODE; else if (timed_out) nxt = HALT;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                          nxt = R_EX;
                    OP_LW, OP_SW:                      nxt = MEM_ADR;
                    OP_BEQ:                            nxt = BRANCH;
                    OP_J:                              nxt = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = I_EX;
                    default:                           nxt = FETCH;
                endcase
            end
            R_EX:    nxt = R_WB;
            R_WB:    nxt = FETCH;
            MEM_ADR: nxt = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:  if (bus.mem_ready) nxt = MEM_WB; else if (timed_out) nxt = HALT;
            MEM_WB:  nxt = FETCH;
            MEM_WR:  if (bus.mem_ready) nxt = FETCH; else if (timed_out) nxt = HALT;
            I_EX:    nxt = I_WB;
            I_WB:    nxt = FETCH;
            BRANCH:  nxt = FETCH;
            JUMP:    nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            // Counts only consecutive unanswered cycles of the current access.
            if (!req_st || bus.mem_ready || nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Outputs decode from state so the async reset silences them immediately.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mdr_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.imm_zext   = 1'b0;
        bus.alu_op     = ALU_NOP;
        bus.pc_src     = 2'b00;
        bus.pc_en      = 1'b0;
        bus.illegal    = 1'b0;
        bus.mem_err    = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.alu_op    = ALU_ADD;
                bus.illegal   = !op_known;
            end
            R_EX: begin
                bus.alu_src_a = 1'b1;
                case (bus.funct)
                    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: bus.alu_op = bus.funct;
                    default:                                             bus.alu_op = ALU_NOP;
                endcase
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            MEM_ADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mdr_write = bus.mem_ready;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            I_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_ADDI: bus.alu_op = ALU_ADD;
                    OP_ANDI: begin bus.alu_op = ALU_AND; bus.imm_zext = 1'b1; end
                    OP_ORI:  begin bus.alu_op = ALU_OR;  bus.imm_zext = 1'b1; end
                    OP_XORI: begin bus.alu_op = ALU_XOR; bus.imm_zext = 1'b1; end
                    default: bus.alu_op = ALU_NOP;
                endcase
            end
            I_WB:    bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            HALT:    bus.mem_err = 1'b1;
            default: ;
        endcase
    end
endmodule
